// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder for the core load/store port
// One request at a time, fixed wait states, lane-masked stores, extended loads.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              rsp_done;
  logic [1:0]        size;
  logic              f3_illegal;
  logic              misaligned;
  logic              out_of_range;
  logic              acc_err;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;
  logic [3:0]        byte_en;
  logic [31:0]       wr_data;
  logic              mem_we;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_ready && req_valid;
  assign commit    = (state == S_BUSY) && (wait_cnt == 4'd0);
  assign rsp_done  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A zero wait count still passes through BUSY once; that cycle is the commit.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_BUSY;
      S_BUSY:  if (commit) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_INIT;
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end else if (state == S_BUSY && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign size = funct3_q[1:0];

  always_comb begin
    f3_illegal = 1'b0;
    if (we_q) begin
      f3_illegal = funct3_q[2] || (funct3_q[1:0] == 2'b11);
    end else begin
      f3_illegal = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
    end
  end

  assign misaligned   = ((size == 2'b01) && addr_q[0]) ||
                        ((size == 2'b10) && (addr_q[1:0] != 2'b00));
  assign out_of_range = |addr_q[31:ADDR_W+2];
  assign acc_err      = f3_illegal || misaligned || out_of_range;

  assign word_idx = addr_q[ADDR_W+1:2];
  assign rd_word  = mem[word_idx];
  assign half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    byte_sel = rd_word[7:0];
    case (addr_q[1:0])
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
  end

  always_comb begin
    load_data = 32'd0;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick placement.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = 32'd0;
    case (size)
      2'b00: begin
        byte_en = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wr_data = wdata_q;
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = 32'd0;
      end
    endcase
  end

  assign mem_we = commit && we_q && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || we_q) ? 32'd0 : load_data;
    end else if (rsp_done) begin
      rsp_rdata <= rsp_rdata;
      rsp_err   <= rsp_err;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Issue one request and wait for rsp_valid; returns at a negedge with the response showing.
  task automatic send_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout addr=%h: rsp_valid never rose", addr);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat);
    send_req(we, f3, addr, wd, lat);
    rd  = rsp_rdata;
    err = rsp_err;
    finish_rsp();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++;
    if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] rd;
    logic        err;
    int          lat;
    do_txn(1'b1, F_W, 32'h10, 32'hDEADBEEF, rd, err, lat);
    checks++;
    if (err !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_rsp got=%h/%b exp=0/0", rd, err); end
    checks++;
    if (lat !== WAIT_CYCLES + 1) begin errors++; $display("FAIL sw_latency got=%0d exp=%0d", lat, WAIT_CYCLES + 1); end
    do_txn(1'b0, F_W, 32'h10, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL lw_data got=%h/%b exp=deadbeef/0", rd, err); end
    checks++;
    if (lat !== WAIT_CYCLES + 1) begin errors++; $display("FAIL lw_latency got=%0d exp=%0d", lat, WAIT_CYCLES + 1); end
    do_txn(1'b1, F_W, 32'hFFC, 32'h0BADF00D, rd, err, lat);
    do_txn(1'b0, F_W, 32'hFFC, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h0BADF00D || err !== 1'b0) begin errors++; $display("FAIL lw_top got=%h/%b exp=0badf00d/0", rd, err); end
  endtask

  task automatic test_byte();
    logic [31:0] rd;
    logic        err;
    int          lat;
    do_txn(1'b1, F_W, 32'h10, 32'h11223344, rd, err, lat);
    do_txn(1'b1, F_B, 32'h13, 32'h000000AA, rd, err, lat);
    do_txn(1'b0, F_W, 32'h10, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hAA223344) begin errors++; $display("FAIL sb_merge got=%h exp=aa223344", rd); end
    do_txn(1'b0, F_B, 32'h13, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hFFFFFFAA || err !== 1'b0) begin errors++; $display("FAIL lb got=%h/%b exp=ffffffaa/0", rd, err); end
    do_txn(1'b0, F_BU, 32'h13, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu got=%h exp=000000aa", rd); end
    do_txn(1'b0, F_B, 32'h11, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h00000033) begin errors++; $display("FAIL lb_lane1 got=%h exp=00000033", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd;
    logic        err;
    int          lat;
    do_txn(1'b1, F_W, 32'h20, 32'h00000000, rd, err, lat);
    do_txn(1'b1, F_H, 32'h22, 32'h00008001, rd, err, lat);
    do_txn(1'b0, F_H, 32'h22, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hFFFF8001 || err !== 1'b0) begin errors++; $display("FAIL lh got=%h/%b exp=ffff8001/0", rd, err); end
    do_txn(1'b0, F_HU, 32'h22, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu got=%h exp=00008001", rd); end
    do_txn(1'b0, F_H, 32'h10, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h00003344) begin errors++; $display("FAIL lh_low got=%h exp=00003344", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        err;
    int          lat;
    do_txn(1'b0, F_W, 32'h11, 32'h0, rd, err, lat);
    checks++;
    if (err !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_lw_mis got=%h/%b exp=0/1", rd, err); end
    do_txn(1'b1, F_H, 32'h23, 32'h0000BEEF, rd, err, lat);
    checks++;
    if (err !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_sh_mis got=%h/%b exp=0/1", rd, err); end
    do_txn(1'b0, F_W, 32'h00001000, 32'h0, rd, err, lat);
    checks++;
    if (err !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_range got=%h/%b exp=0/1", rd, err); end
    do_txn(1'b1, F_W, 32'h00001010, 32'h55555555, rd, err, lat);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sw_range got=%b exp=1", err); end
    do_txn(1'b0, 3'b011, 32'h10, 32'h0, rd, err, lat);
    checks++;
    if (err !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_ld_f3 got=%h/%b exp=0/1", rd, err); end
    do_txn(1'b1, 3'b100, 32'h10, 32'h00000055, rd, err, lat);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_st_f3 got=%b exp=1", err); end
    do_txn(1'b0, F_W, 32'h20, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'h80010000 || err !== 1'b0) begin errors++; $display("FAIL err_nowrite20 got=%h/%b exp=80010000/0", rd, err); end
    do_txn(1'b0, F_W, 32'h10, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hAA223344) begin errors++; $display("FAIL err_nowrite10 got=%h exp=aa223344", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int          lat;
    send_req(1'b0, F_W, 32'h10, 32'h0, lat);
    held = rsp_rdata;
    checks++;
    if (held !== 32'hAA223344) begin errors++; $display("FAIL bp_data got=%h exp=aa223344", held); end
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== held) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got=%b/%b/%h exp=1/0/%h", i, rsp_valid, req_ready, rsp_rdata, held);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got=%b/%b exp=0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic        err;
    int          lat;
    do_txn(1'b1, F_W, 32'h30, 32'hCAFEF00D, rd, err, lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F_W;
    req_addr   = 32'h30;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_async got=%b/%b exp=0/1", rsp_valid, req_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle got=%b/%b exp=0/1", rsp_valid, req_ready);
    end
    do_txn(1'b0, F_W, 32'h30, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || err !== 1'b0) begin errors++; $display("FAIL abort_nowrite got=%h/%b exp=cafef00d/0", rd, err); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
